// File: rtl/sub_operand_sequencer.sv
// -----------------------------------------------------------------------------
// sub_operand_sequencer
//
// Board-side wrapper around an external n-bit subtractor. Two presses of a
// single load button capture the minuend and then the subtrahend from one
// switch bus. The captured operands drive the subtractor. One cycle later the
// difference, borrow and overflow are registered, together with the derived
// negative and zero flags, for the display logic.
//
// A press made while a result is on display loads a new minuend straight
// away. The old result stays visible, but valid drops until the next
// subtraction completes.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous active-high reset
//   data_in   in   n   switch bus, sampled only on a load event
//   load_btn  in   1   raw asynchronous load button (level)
//   clear     in   1   synchronous abort; same effect as rst
//   A_op      out  n   registered minuend to subtractor .A
//   B_op      out  n   registered subtrahend to subtractor .B
//   D_in      in   n   subtractor difference
//   Bout_in   in   1   subtractor final borrow
//   V_in      in   1   subtractor signed overflow
//   result    out  n   registered difference
//   flag_n    out  1   result MSB
//   flag_z    out  1   result == 0
//   flag_c    out  1   registered borrow (A < B unsigned)
//   flag_v    out  1   registered signed overflow
//   valid     out  1   result/flags hold a completed subtraction
//   state     out  2   FSM state code for LEDs
// -----------------------------------------------------------------------------
module sub_operand_sequencer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] data_in,
    input  logic         load_btn,
    input  logic         clear,
    output logic [n-1:0] A_op,
    output logic [n-1:0] B_op,
    input  logic [n-1:0] D_in,
    input  logic         Bout_in,
    input  logic         V_in,
    output logic [n-1:0] result,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v,
    output logic         valid,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] a_q, a_d;
    logic [n-1:0] b_q, b_d;
    logic [n-1:0] res_q, res_d;
    logic         n_q, n_d;
    logic         z_q, z_d;
    logic         c_q, c_d;
    logic         v_q, v_d;
    logic         valid_q, valid_d;

    // Bit 0 and bit 1 form the two-flop synchroniser. Bit 2 holds the previous
    // synchronised level, which is used for rising-edge detection.
    logic [2:0]   sync_q;
    logic         load_ev;
    logic         sync_rst;

    // clear behaves exactly like rst. Because it takes the reset branch, it
    // also wins over a load event that arrives in the same cycle.
    assign sync_rst = rst | clear;

    // A button held for any length produces a single one-cycle pulse here.
    assign load_ev  = sync_q[1] & ~sync_q[2];

    // NOTE: clocked state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], load_btn};
        end
    end

    // NOTE: each variable gets a hold-value default before the case
    // statement. Without it, a path that does not assign the variable would
    // infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        valid_d = valid_q;

        case (state_q)
            WAIT_A: begin
                if (load_ev) begin
                    a_d     = data_in;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (load_ev) begin
                    b_d     = data_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The operands have been registered for at least one cycle,
                // so the subtractor outputs have settled. A load event in
                // this cycle is dropped on purpose.
                res_d   = D_in;
                n_d     = D_in[n-1];
                z_d     = (D_in == '0);
                c_d     = Bout_in;
                v_d     = V_in;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // A press here starts the next operation. The old result
                // and flags stay visible until the next EXEC overwrites them.
                if (load_ev) begin
                    a_d     = data_in;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            valid_q <= valid_d;
        end
    end

    assign A_op   = a_q;
    assign B_op   = b_q;
    assign result = res_q;
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_v = v_q;
    assign valid  = valid_q;
    assign state  = state_q;

endmodule
